// File: rtl/gpu_pkg.sv
// Shared types and constants for the AXI4-Lite raster engine.
package gpu_pkg;

  // CMD register opcodes
  typedef enum logic [1:0] {
    OpNop   = 2'd0,
    OpPixel = 2'd1,
    OpFill  = 2'd2,
    OpClear = 2'd3
  } opcode_e;

  // Register indices, decoded from addr[4:2]
  localparam logic [2:0] RegCmd    = 3'd0;
  localparam logic [2:0] RegStatus = 3'd1;
  localparam logic [2:0] RegP0     = 3'd2;
  localparam logic [2:0] RegP1     = 3'd3;
  localparam logic [2:0] RegColor  = 3'd4;
  localparam logic [2:0] RegId     = 3'd7;

  localparam logic [31:0] GpuId     = 32'h4750_5531;
  localparam logic [1:0]  RespOkay  = 2'b00;

endpackage

// File: rtl/gpu_raster_engine.sv
// Rectangle rasteriser: latches a clipped rectangle at start and streams one pixel per clock
// into the framebuffer write port, x inner loop, y outer loop.
module gpu_raster_engine
  import gpu_pkg::*;
#(
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned FBUF_DATA_WIDTH = 8,
  parameter int unsigned SCREEN_WIDTH    = 640,
  parameter int unsigned SCREEN_HEIGHT   = 480
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  opcode_e                    i_op,
  input  logic [15:0]                i_x0,
  input  logic [15:0]                i_y0,
  input  logic [15:0]                i_x1,
  input  logic [15:0]                i_y1,
  input  logic [FBUF_DATA_WIDTH-1:0] i_color,
  output logic                       o_busy,
  output logic                       o_fbuf_en,
  output logic                       o_fbuf_we,
  output logic [FBUF_ADDR_WIDTH-1:0] o_fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] o_fbuf_data
);

  typedef enum logic {StIdle, StDraw} state_e;

  localparam logic [15:0] XMax = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] YMax = 16'(SCREEN_HEIGHT - 1);
  localparam logic [FBUF_ADDR_WIDTH-1:0] RowStep = FBUF_ADDR_WIDTH'(SCREEN_WIDTH);

  state_e                     r_state;
  logic                       r_busy;
  logic                       r_en;
  logic [FBUF_ADDR_WIDTH-1:0] r_addr;
  logic [FBUF_ADDR_WIDTH-1:0] r_row_base;
  logic [FBUF_DATA_WIDTH-1:0] r_data;
  logic [15:0]                r_x, r_y, r_xs, r_xe, r_ye;

  logic [15:0]                w_x0, w_y0, w_x1, w_y1;
  logic                       w_empty;
  logic                       w_last;
  logic [FBUF_ADDR_WIDTH-1:0] w_row_base;
  logic [FBUF_ADDR_WIDTH-1:0] w_next_row;

  // Resolve the launch rectangle for the opcode, clamping the far corner to the screen
  always_comb begin
    w_x0 = i_x0;
    w_y0 = i_y0;
    w_x1 = (i_x1 > XMax) ? XMax : i_x1;
    w_y1 = (i_y1 > YMax) ? YMax : i_y1;
    case (i_op)
      OpPixel: begin
        w_x1 = i_x0;
        w_y1 = i_y0;
      end
      OpClear: begin
        w_x0 = '0;
        w_y0 = '0;
        w_x1 = XMax;
        w_y1 = YMax;
      end
      default: ;
    endcase
    w_empty = (w_x0 > w_x1) || (w_y0 > w_y1) || (w_x0 > XMax) || (w_y0 > YMax);
    // Constant multiply happens once per launch only; the loop itself just adds RowStep.
    w_row_base = FBUF_ADDR_WIDTH'(32'(w_y0) * 32'(SCREEN_WIDTH));
    w_last     = (r_x == r_xe) && (r_y == r_ye);
    w_next_row = r_row_base + RowStep;
  end

  // Engine FSM with registered pixel outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_en       <= 1'b0;
      r_addr     <= '0;
      r_row_base <= '0;
      r_data     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_xs       <= '0;
      r_xe       <= '0;
      r_ye       <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_en <= 1'b0;
          if (i_start) begin
            r_state    <= StDraw;
            r_busy     <= 1'b1;
            // An empty rectangle still spends one busy cycle in StDraw, with no pixel.
            r_en       <= !w_empty;
            r_x        <= w_x0;
            r_y        <= w_y0;
            r_xs       <= w_x0;
            r_xe       <= w_x1;
            r_ye       <= w_y1;
            r_row_base <= w_row_base;
            r_addr     <= w_row_base + FBUF_ADDR_WIDTH'(w_x0);
            r_data     <= i_color;
          end
        end
        StDraw: begin
          if (!r_en || w_last) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_en    <= 1'b0;
          end else if (r_x == r_xe) begin
            r_x        <= r_xs;
            r_y        <= r_y + 16'd1;
            r_row_base <= w_next_row;
            r_addr     <= w_next_row + FBUF_ADDR_WIDTH'(r_xs);
          end else begin
            r_x    <= r_x + 16'd1;
            r_addr <= r_addr + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_fbuf_en   = r_en;
  assign o_fbuf_we   = r_en;
  assign o_fbuf_addr = r_addr;
  assign o_fbuf_data = r_data;

endmodule

// File: rtl/axi4_lite_gpu.sv
// AXI4-Lite control slave for the raster engine: register file, read/write channel
// handshakes and command launch into gpu_raster_engine.
module axi4_lite_gpu
  import gpu_pkg::*;
#(
  parameter int unsigned AXI_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH    = 32,
  parameter int unsigned FBUF_ADDR_WIDTH   = 19,
  parameter int unsigned FBUF_DATA_WIDTH   = 8,
  parameter int unsigned SCREEN_WIDTH      = 640,
  parameter int unsigned SCREEN_HEIGHT     = 480
) (
  input  logic                         s_axi_ctrl_aclk,
  input  logic                         s_axi_ctrl_areset,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_araddr,
  input  logic                         s_axi_ctrl_arvalid,
  output logic                         s_axi_ctrl_arready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_rdata,
  output logic [1:0]                   s_axi_ctrl_rresp,
  output logic                         s_axi_ctrl_rvalid,
  input  logic                         s_axi_ctrl_rready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_awaddr,
  input  logic                         s_axi_ctrl_awvalid,
  output logic                         s_axi_ctrl_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_wdata,
  input  logic                         s_axi_ctrl_wvalid,
  output logic                         s_axi_ctrl_wready,
  output logic [1:0]                   s_axi_ctrl_bresp,
  output logic                         s_axi_ctrl_bvalid,
  input  logic                         s_axi_ctrl_bready,
  output logic                         fbuf_en_wr,
  output logic                         fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]   fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]   fbuf_data
);

  logic                      r_awready, r_wready, r_bvalid;
  logic                      r_arready, r_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;

  opcode_e                   r_cmd;
  logic                      r_dropped;
  logic [31:0]               r_p0, r_p1;
  logic [7:0]                r_color;

  logic                      w_busy;
  logic                      w_wr_en;
  logic [2:0]                w_wr_sel, w_rd_sel;
  opcode_e                   w_op;
  logic                      w_cmd_wr, w_launch, w_drop;
  logic [AXI_DATA_WIDTH-1:0] w_rd_data;
  logic                      w_unused;

  assign w_wr_sel = s_axi_ctrl_awaddr[4:2];
  assign w_rd_sel = s_axi_ctrl_araddr[4:2];
  assign w_op     = opcode_e'(s_axi_ctrl_wdata[1:0]);
  assign w_wr_en  = r_awready && s_axi_ctrl_awvalid && s_axi_ctrl_wvalid;
  assign w_cmd_wr = w_wr_en && (w_wr_sel == RegCmd);
  assign w_launch = w_cmd_wr && (w_op != OpNop) && !w_busy;
  assign w_drop   = w_cmd_wr && (w_op != OpNop) && w_busy;
  assign w_unused = ^{s_axi_ctrl_awaddr[AXI_ADDRESS_WIDTH-1:5], s_axi_ctrl_awaddr[1:0],
                      s_axi_ctrl_araddr[AXI_ADDRESS_WIDTH-1:5], s_axi_ctrl_araddr[1:0]};

  // Write channel: one-cycle aw/w ready pulse, then hold bvalid until bready
  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (s_axi_ctrl_areset) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      if (r_awready) begin
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
        r_bvalid  <= 1'b1;
      end else if (s_axi_ctrl_awvalid && s_axi_ctrl_wvalid && !r_bvalid) begin
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
      if (r_bvalid && s_axi_ctrl_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register file updates on the write handshake cycle
  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (s_axi_ctrl_areset) begin
      r_cmd     <= OpNop;
      r_dropped <= 1'b0;
      r_p0      <= '0;
      r_p1      <= '0;
      r_color   <= '0;
    end else begin
      if (w_wr_en) begin
        case (w_wr_sel)
          RegCmd:    r_cmd <= w_op;
          RegStatus: if (s_axi_ctrl_wdata[1]) r_dropped <= 1'b0;
          RegP0:     r_p0 <= s_axi_ctrl_wdata[31:0];
          RegP1:     r_p1 <= s_axi_ctrl_wdata[31:0];
          RegColor:  r_color <= s_axi_ctrl_wdata[7:0];
          default: ;
        endcase
      end
      // w_drop only occurs on CMD writes, so it never races the W1C above.
      if (w_drop) begin
        r_dropped <= 1'b1;
      end
    end
  end

  // Read data mux
  always_comb begin
    w_rd_data = '0;
    case (w_rd_sel)
      RegCmd:    w_rd_data[1:0] = r_cmd;
      RegStatus: begin
        w_rd_data[0] = w_busy;
        w_rd_data[1] = r_dropped;
      end
      RegP0:     w_rd_data = AXI_DATA_WIDTH'(r_p0);
      RegP1:     w_rd_data = AXI_DATA_WIDTH'(r_p1);
      RegColor:  w_rd_data[7:0] = r_color;
      RegId:     w_rd_data = AXI_DATA_WIDTH'(GpuId);
      default: ;
    endcase
  end

  // Read channel: one-cycle arready pulse, registered rdata held until rready
  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (s_axi_ctrl_areset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (r_arready) begin
        r_arready <= 1'b0;
        if (s_axi_ctrl_arvalid) begin
          r_rvalid <= 1'b1;
          r_rdata  <= w_rd_data;
        end
      end else if (s_axi_ctrl_arvalid && !r_rvalid) begin
        r_arready <= 1'b1;
      end
      if (r_rvalid && s_axi_ctrl_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  gpu_raster_engine #(
    .FBUF_ADDR_WIDTH (FBUF_ADDR_WIDTH),
    .FBUF_DATA_WIDTH (FBUF_DATA_WIDTH),
    .SCREEN_WIDTH    (SCREEN_WIDTH),
    .SCREEN_HEIGHT   (SCREEN_HEIGHT)
  ) u_engine (
    .i_clk       (s_axi_ctrl_aclk),
    .i_rst       (s_axi_ctrl_areset),
    .i_start     (w_launch),
    .i_op        (w_op),
    .i_x0        (r_p0[15:0]),
    .i_y0        (r_p0[31:16]),
    .i_x1        (r_p1[15:0]),
    .i_y1        (r_p1[31:16]),
    .i_color     (FBUF_DATA_WIDTH'(r_color)),
    .o_busy      (w_busy),
    .o_fbuf_en   (fbuf_en_wr),
    .o_fbuf_we   (fbuf_wrea),
    .o_fbuf_addr (fbuf_addr),
    .o_fbuf_data (fbuf_data)
  );

  assign s_axi_ctrl_arready = r_arready;
  assign s_axi_ctrl_rdata   = r_rdata;
  assign s_axi_ctrl_rresp   = RespOkay;
  assign s_axi_ctrl_rvalid  = r_rvalid;
  assign s_axi_ctrl_awready = r_awready;
  assign s_axi_ctrl_wready  = r_wready;
  assign s_axi_ctrl_bresp   = RespOkay;
  assign s_axi_ctrl_bvalid  = r_bvalid;

endmodule

// File: tb/tb_axi4_lite_gpu.sv
// Directed bench for axi4_lite_gpu: register access, pixel/fill/clip/drop behaviour, reset.
module tb_axi4_lite_gpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        fbuf_en_wr, fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int busy_cnt = 0;
  int we_bad = 0;
  int unsigned q_addr[$];
  int unsigned q_data[$];
  int q_cyc[$];

  axi4_lite_gpu dut (
    .s_axi_ctrl_aclk    (clk),
    .s_axi_ctrl_areset  (rst),
    .s_axi_ctrl_araddr  (araddr),
    .s_axi_ctrl_arvalid (arvalid),
    .s_axi_ctrl_arready (arready),
    .s_axi_ctrl_rdata   (rdata),
    .s_axi_ctrl_rresp   (rresp),
    .s_axi_ctrl_rvalid  (rvalid),
    .s_axi_ctrl_rready  (rready),
    .s_axi_ctrl_awaddr  (awaddr),
    .s_axi_ctrl_awvalid (awvalid),
    .s_axi_ctrl_awready (awready),
    .s_axi_ctrl_wdata   (wdata),
    .s_axi_ctrl_wvalid  (wvalid),
    .s_axi_ctrl_wready  (wready),
    .s_axi_ctrl_bresp   (bresp),
    .s_axi_ctrl_bvalid  (bvalid),
    .s_axi_ctrl_bready  (bready),
    .fbuf_en_wr         (fbuf_en_wr),
    .fbuf_wrea          (fbuf_wrea),
    .fbuf_addr          (fbuf_addr),
    .fbuf_data          (fbuf_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (fbuf_en_wr === 1'b1) begin
      q_addr.push_back(int'(fbuf_addr));
      q_data.push_back(int'(fbuf_data));
      q_cyc.push_back(cyc);
    end
    if (dut.w_busy === 1'b1) busy_cnt = busy_cnt + 1;
    if (fbuf_wrea !== fbuf_en_wr) we_bad = we_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    busy_cnt = 0;
  endtask

  // Returns in the cycle after the write handshake (engine's first pixel cycle).
  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data);
    int n;
    awaddr  = addr;
    wdata   = data;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!awready && n < 20);
    if (!awready) begin
      chk("wr_timeout", 32'd0, 32'd1);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      return;
    end
    chk("wready_with_awready", 32'(wready), 32'd1);
    hs_cyc = cyc;
    tick(1);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'd0);
  endtask

  task automatic axi_rd(input logic [31:0] addr, input int hold, output logic [31:0] data);
    int n;
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b0;
    data    = '0;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!arready && n < 20);
    if (!arready) begin
      chk("rd_timeout", 32'd0, 32'd1);
      arvalid = 1'b0;
      return;
    end
    tick(1);
    arvalid = 1'b0;
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("rresp", 32'(rresp), 32'd0);
    data = rdata;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_hold", rdata, data);
    end
    rready = 1'b1;
    tick(1);
    rready = 1'b0;
    chk("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  logic [31:0] rd;
  int seq_err;
  int exp_fill[6] = '{3210, 3211, 3212, 3850, 3851, 3852};

  initial begin
    // Reset with all master valids asserted
    arvalid = 1'b1;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("reset_outputs", {26'd0, arready, awready, wready, rvalid, bvalid, fbuf_en_wr}, 32'd0);
    end
    chk("reset_rdata", rdata, 32'd0);
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    rst     = 1'b0;
    tick(2);

    // ID, unmapped read, held rdata
    axi_rd(32'h1C, 0, rd);
    chk("id", rd, 32'h4750_5531);
    axi_rd(32'h18, 0, rd);
    chk("unmapped_rd", rd, 32'd0);
    axi_rd(32'h1C, 3, rd);
    chk("id_held", rd, 32'h4750_5531);

    // Single pixel at (3,2)
    axi_wr(32'h08, 32'h0002_0003);
    axi_wr(32'h10, 32'h0000_00A5);
    tick(3);
    clear_log();
    axi_wr(32'h00, 32'd1);
    tick(4);
    chk("pixel_count", 32'(q_addr.size()), 32'd1);
    if (q_addr.size() >= 1) begin
      chk("pixel_addr", q_addr[0], 32'd1283);
      chk("pixel_data", q_data[0], 32'hA5);
      chk("pixel_latency", 32'(q_cyc[0]), 32'(hs_cyc + 1));
    end
    axi_rd(32'h04, 0, rd);
    chk("pixel_status", rd, 32'd0);
    axi_rd(32'h00, 0, rd);
    chk("last_cmd", rd, 32'd1);

    // FILL (10,5)-(12,6)
    axi_wr(32'h08, 32'h0005_000A);
    axi_wr(32'h0C, 32'h0006_000C);
    axi_wr(32'h10, 32'h0000_003C);
    tick(3);
    clear_log();
    axi_wr(32'h00, 32'd2);
    tick(10);
    chk("fill_count", 32'(q_addr.size()), 32'd6);
    chk("fill_busy_cycles", 32'(busy_cnt), 32'd6);
    if (q_addr.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("fill_addr", q_addr[i], 32'(exp_fill[i]));
        chk("fill_data", q_data[i], 32'h3C);
        chk("fill_cyc", 32'(q_cyc[i]), 32'(hs_cyc + 1 + i));
      end
    end

    // Clipped FILL at the bottom-right corner
    axi_wr(32'h08, 32'h01DF_027E);
    axi_wr(32'h0C, 32'h0384_02BC);
    tick(3);
    clear_log();
    axi_wr(32'h00, 32'd2);
    tick(6);
    chk("clip_count", 32'(q_addr.size()), 32'd2);
    if (q_addr.size() == 2) begin
      chk("clip_addr0", q_addr[0], 32'd307198);
      chk("clip_addr1", q_addr[1], 32'd307199);
    end

    // Empty rectangle: no pixels, one busy cycle
    axi_wr(32'h08, 32'h0005_0005);
    axi_wr(32'h0C, 32'h0005_0003);
    tick(3);
    clear_log();
    axi_wr(32'h00, 32'd2);
    tick(5);
    chk("empty_count", 32'(q_addr.size()), 32'd0);
    chk("empty_busy_cycles", 32'(busy_cnt), 32'd1);

    // 10-pixel FILL with NOP during draw: not dropped
    axi_wr(32'h08, 32'h0000_0000);
    axi_wr(32'h0C, 32'h0000_0009);
    tick(3);
    clear_log();
    axi_wr(32'h00, 32'd2);
    axi_wr(32'h00, 32'd0);
    tick(15);
    chk("nop_busy_count", 32'(q_addr.size()), 32'd10);
    axi_rd(32'h04, 0, rd);
    chk("nop_no_drop", rd, 32'd0);

    // Same FILL with PIXEL during draw: dropped, then W1C
    clear_log();
    axi_wr(32'h00, 32'd2);
    axi_wr(32'h00, 32'd1);
    tick(15);
    chk("drop_count", 32'(q_addr.size()), 32'd10);
    axi_rd(32'h04, 0, rd);
    chk("drop_status", rd, 32'd2);
    axi_wr(32'h04, 32'd2);
    tick(2);
    axi_rd(32'h04, 0, rd);
    chk("drop_w1c", rd, 32'd0);

    // CLEAR, partially observed, then reset mid-draw
    axi_wr(32'h10, 32'd0);
    tick(3);
    clear_log();
    axi_wr(32'h00, 32'd3);
    tick(1000);
    chk("clear_progress", 32'(q_addr.size() >= 1000), 32'd1);
    seq_err = 0;
    for (int i = 0; i < q_addr.size(); i++) begin
      if (q_addr[i] != i || q_data[i] != 0 || q_cyc[i] != hs_cyc + 1 + i) seq_err++;
    end
    chk("clear_sequence", 32'(seq_err), 32'd0);
    chk("clear_busy_now", 32'(dut.w_busy), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("midreset_fbuf_en", 32'(fbuf_en_wr), 32'd0);
    chk("midreset_busy", 32'(dut.w_busy), 32'd0);
    rst = 1'b0;
    tick(2);
    axi_rd(32'h00, 0, rd);
    chk("midreset_cmd", rd, 32'd0);
    axi_rd(32'h04, 0, rd);
    chk("midreset_status", rd, 32'd0);
    axi_rd(32'h08, 0, rd);
    chk("midreset_p0", rd, 32'd0);
    axi_rd(32'h0C, 0, rd);
    chk("midreset_p1", rd, 32'd0);
    chk("wrea_tracks_en", 32'(we_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_gpu.md
Name: axi4_lite_gpu

Overview:
- AXI4-Lite slave holding control registers for a minimal 2D raster engine.
- Engine writes 8-bit pixels into a write-only framebuffer BRAM port, one pixel per clock.
- Sits between the PS AXI GP master and the framebuffer BRAM; the display scan-out side reads the other BRAM port.

Parameters:
AXI_ADDRESS_WIDTH, 32, AXI address width.
AXI_DATA_WIDTH, 32, AXI data width (register map assumes 32).
FBUF_ADDR_WIDTH, 19, framebuffer word address width.
FBUF_DATA_WIDTH, 8, pixel width.
SCREEN_WIDTH, 640, pixels per row.
SCREEN_HEIGHT, 480, rows.

Ports:
s_axi_ctrl_aclk  in  1  single clock, all logic on rising edge
s_axi_ctrl_areset  in  1  synchronous, active-high reset
s_axi_ctrl_araddr  in  AXI_ADDRESS_WIDTH  read address
s_axi_ctrl_arvalid/arready  in/out  1  read address handshake
s_axi_ctrl_rdata  out  AXI_DATA_WIDTH  read data
s_axi_ctrl_rresp  out  2  always 2'b00 OKAY
s_axi_ctrl_rvalid/rready  out/in  1  read data handshake
s_axi_ctrl_awaddr  in  AXI_ADDRESS_WIDTH  write address
s_axi_ctrl_awvalid/awready  in/out  1  write address handshake
s_axi_ctrl_wdata  in  AXI_DATA_WIDTH  write data; no strobes, full-word writes only
s_axi_ctrl_wvalid/wready  in/out  1  write data handshake
s_axi_ctrl_bresp  out  2  always 2'b00
s_axi_ctrl_bvalid/bready  out/in  1  write response handshake
fbuf_en_wr  out  1  BRAM port enable
fbuf_wrea  out  1  BRAM write enable
fbuf_addr  out  FBUF_ADDR_WIDTH  pixel address = y*SCREEN_WIDTH + x
fbuf_data  out  FBUF_DATA_WIDTH  pixel value

Behaviour:
- Reset (sampled at posedge while s_axi_ctrl_areset=1):
  - All ready, valid and fbuf_* outputs are 0; rdata = 0.
  - All registers are 0; the engine returns to IDLE, including when reset arrives mid-draw.
- Register map: decode addr[4:2]; upper bits ignored.
  - 0x00 CMD: W [1:0] opcode (0 NOP, 1 PIXEL, 2 FILL, 3 CLEAR); R last opcode.
  - 0x04 STATUS: R bit0 busy, bit1 dropped (sticky); W1C bit1.
  - 0x08 P0: [15:0] x0, [31:16] y0.
  - 0x0C P1: [15:0] x1, [31:16] y1.
  - 0x10 COLOR: [7:0].
  - 0x1C ID: R constant 0x47505531. Unmapped reads return 0; unmapped writes are ignored.
- Write channel:
  - awready and wready pulse high together for one cycle when awvalid && wvalid && !bvalid && !awready.
  - The register update happens on that cycle; bvalid rises the next cycle and holds until bready.
- Read channel:
  - arready pulses one cycle when arvalid && !rvalid && !arready.
  - rdata/rvalid are registered the next cycle; rvalid holds until rready.
  - Read and write paths are independent and may complete in the same cycle.
- Command launch:
  - A CMD write with opcode 1-3 while idle starts the engine.
  - While busy, the command is ignored and dropped is set.
  - NOP never sets dropped. P0/P1/COLOR writes during busy update the registers; the engine uses values latched at launch.
- Engine FSM: IDLE -> DRAW -> IDLE.
  - Launch at write handshake cycle T: busy=1 and the first pixel on fbuf_* at T+1.
  - One pixel per cycle, x inner loop, y outer loop.
  - busy=0 on the cycle after the last pixel.
  - fbuf_en_wr = fbuf_wrea = 1 only on pixel cycles.
- Opcodes:
  - PIXEL: writes (x0,y0).
  - FILL: writes the rectangle x0..x1 by y0..y1 inclusive.
  - CLEAR: writes 0..SCREEN_WIDTH-1 by 0..SCREEN_HEIGHT-1.
  - All use the latched COLOR[FBUF_DATA_WIDTH-1:0].
- Clipping:
  - x1 is clamped to SCREEN_WIDTH-1 and y1 to SCREEN_HEIGHT-1.
  - If x0>x1, y0>y1, x0≥SCREEN_WIDTH or y0≥SCREEN_HEIGHT after clamp, no pixels are written, and busy pulses exactly one cycle.
- Address generation is incremental (row base += SCREEN_WIDTH) with no multiplier in the loop; the result is truncated to FBUF_ADDR_WIDTH.

Decomposition:
- Package gpu_pkg: opcode enum, register offset constants, ID constant, AXI resp constants.
- Sub-module gpu_raster_engine: latched rect/color inputs, start, busy, fbuf_* outputs.
- axi4_lite_gpu keeps the AXI FSMs and the register file.

Test Plan:
- Hold reset 10 cycles with all master valids high -> arready/awready/wready/rvalid/bvalid stay 0 every reset cycle; fbuf_en_wr=0.
- Read 0x1C -> rdata=0x47505531, rresp=0; read 0x18 -> 0. Delay rready 3 cycles -> rvalid and rdata held stable.
- Write P0=0x0002_0003, COLOR=0xA5, CMD=1 -> exactly one fbuf write at addr 1283 (2*640+3), data 0xA5, at T+1; STATUS busy is 0 afterwards.
- FILL P0=(10,5) P1=(12,6), COLOR=0x3C -> 6 writes in order at addr 3210, 3211, 3212, 3850, 3851, 3852; busy high for exactly 6 cycles.
- FILL P0=(638,479) P1=(700,900) -> clipped to 2 writes at addr 307198 and 307199; CMD write during draw -> ignored, STATUS=0x2 after; writing STATUS=0x2 clears it to 0.
- CLEAR with COLOR=0 -> 307200 consecutive writes from addr 0 to 307199; assert reset mid-clear -> fbuf_en_wr=0 next cycle, busy=0, registers zero.
